// File: rtl/alu_seq.sv
// alu_seq: execution stage producing a registered result and a persistent {N,V,C,Z} flags register.
// Single-cycle arithmetic/logic ops. MUL/MULH run a DATA_BUS_WIDTH-step shift-add multiplier
// behind a start/busy/done handshake.
module alu_seq #(
  parameter int unsigned DATA_BUS_WIDTH = 8
) (
  input  logic                      clock,
  input  logic                      reset,
  input  logic                      start,
  input  logic [3:0]                op,
  input  logic [DATA_BUS_WIDTH-1:0] a,
  input  logic [DATA_BUS_WIDTH-1:0] b,
  output logic [DATA_BUS_WIDTH-1:0] result,
  output logic [3:0]                flags,
  output logic                      busy,
  output logic                      done
);

  localparam int unsigned W  = DATA_BUS_WIDTH;
  localparam int unsigned CW = (W > 1) ? $clog2(W) : 1;

  localparam logic [3:0] OP_ADD  = 4'h0;
  localparam logic [3:0] OP_ADC  = 4'h1;
  localparam logic [3:0] OP_SUB  = 4'h2;
  localparam logic [3:0] OP_SBC  = 4'h3;
  localparam logic [3:0] OP_AND  = 4'h4;
  localparam logic [3:0] OP_OR   = 4'h5;
  localparam logic [3:0] OP_XOR  = 4'h6;
  localparam logic [3:0] OP_NOT  = 4'h7;
  localparam logic [3:0] OP_SHL  = 4'h8;
  localparam logic [3:0] OP_SHR  = 4'h9;
  localparam logic [3:0] OP_ROL  = 4'hA;
  localparam logic [3:0] OP_INC  = 4'hB;
  localparam logic [3:0] OP_DEC  = 4'hC;
  localparam logic [3:0] OP_MUL  = 4'hD;
  localparam logic [3:0] OP_MULH = 4'hE;
  localparam logic [3:0] OP_CMP  = 4'hF;

  localparam logic [0:0] ST_IDLE = 1'b0;
  localparam logic [0:0] ST_MUL  = 1'b1;

  logic [0:0]     state_q, state_d;
  logic [W-1:0]   result_q, result_d;
  logic [3:0]     flags_q, flags_d;
  logic           done_q, done_d;
  logic [2*W-1:0] acc_q, acc_d;
  logic [W-1:0]   mcand_q, mcand_d;
  logic           mulh_q, mulh_d;
  logic [CW-1:0]  cnt_q, cnt_d;

  logic [W:0]     sum_w;
  logic [W-1:0]   alu_val;
  logic           alu_wr;
  logic           alu_c;
  logic           alu_v;
  logic [3:0]     alu_flags;
  logic           cin;

  logic [W:0]     mul_sum;
  logic [2*W-1:0] mul_next;
  logic [W-1:0]   mul_res;
  logic           mul_c;

  assign result = result_q;
  assign flags  = flags_q;
  assign busy   = (state_q == ST_MUL);
  assign done   = done_q;
  assign cin    = flags_q[1];

  // Single-cycle datapath: value driving N/Z, carry, overflow and whether result is written
  always_comb begin
    sum_w   = '0;
    alu_val = result_q;
    alu_wr  = 1'b1;
    alu_c   = cin;
    alu_v   = 1'b0;
    unique case (op)
      OP_ADD, OP_ADC: begin
        sum_w   = {1'b0, a} + {1'b0, b} + ((op == OP_ADC) ? (W+1)'(cin) : '0);
        alu_val = sum_w[W-1:0];
        alu_c   = sum_w[W];
        alu_v   = (a[W-1] == b[W-1]) && (sum_w[W-1] != a[W-1]);
      end
      OP_SUB, OP_SBC, OP_CMP: begin
        sum_w   = {1'b0, a} - {1'b0, b} - ((op == OP_SBC) ? (W+1)'(cin) : '0);
        alu_val = sum_w[W-1:0];
        alu_c   = sum_w[W];
        alu_v   = (a[W-1] != b[W-1]) && (sum_w[W-1] != a[W-1]);
        alu_wr  = (op != OP_CMP);
      end
      OP_AND: alu_val = a & b;
      OP_OR:  alu_val = a | b;
      OP_XOR: alu_val = a ^ b;
      OP_NOT: alu_val = ~a;
      OP_SHL: begin
        alu_val = {a[W-2:0], 1'b0};
        alu_c   = a[W-1];
      end
      OP_SHR: begin
        alu_val = {1'b0, a[W-1:1]};
        alu_c   = a[0];
      end
      OP_ROL: begin
        alu_val = {a[W-2:0], cin};
        alu_c   = a[W-1];
      end
      OP_INC: begin
        alu_val = a + W'(1);
        alu_v   = (a == {1'b0, {(W-1){1'b1}}});
      end
      OP_DEC: begin
        alu_val = a - W'(1);
        alu_v   = (a == {1'b1, {(W-1){1'b0}}});
      end
      default: alu_wr = 1'b0;
    endcase
    alu_flags = {alu_val[W-1], alu_v, alu_c, (alu_val == '0)};
  end

  // Next state: accept ops when idle, step the shift-add multiplier while busy
  always_comb begin
    state_d  = state_q;
    result_d = result_q;
    flags_d  = flags_q;
    done_d   = 1'b0;
    acc_d    = acc_q;
    mcand_d  = mcand_q;
    mulh_d   = mulh_q;
    cnt_d    = cnt_q;

    // acc holds {partial product, remaining multiplier bits}; add then shift right
    mul_sum  = {1'b0, acc_q[2*W-1:W]} + (acc_q[0] ? {1'b0, mcand_q} : '0);
    mul_next = {mul_sum, acc_q[W-1:1]};
    mul_res  = mulh_q ? mul_next[2*W-1:W] : mul_next[W-1:0];
    mul_c    = mulh_q ? (mul_next[W-1:0] != '0) : (mul_next[2*W-1:W] != '0);

    unique case (state_q)
      ST_IDLE: begin
        if (start) begin
          if (op == OP_MUL || op == OP_MULH) begin
            state_d = ST_MUL;
            acc_d   = {W'(0), b};
            mcand_d = a;
            mulh_d  = (op == OP_MULH);
            cnt_d   = '0;
          end else begin
            if (alu_wr) result_d = alu_val;
            flags_d = alu_flags;
            done_d  = 1'b1;
          end
        end
      end
      ST_MUL: begin
        acc_d = mul_next;
        cnt_d = cnt_q + CW'(1);
        if (cnt_q == CW'(W-1)) begin
          state_d  = ST_IDLE;
          done_d   = 1'b1;
          result_d = mul_res;
          flags_d  = {mul_res[W-1], 1'b0, mul_c, (mul_res == '0)};
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // State register with synchronous reset
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q  <= ST_IDLE;
      result_q <= '0;
      flags_q  <= '0;
      done_q   <= 1'b0;
      acc_q    <= '0;
      mcand_q  <= '0;
      mulh_q   <= 1'b0;
      cnt_q    <= '0;
    end else begin
      state_q  <= state_d;
      result_q <= result_d;
      flags_q  <= flags_d;
      done_q   <= done_d;
      acc_q    <= acc_d;
      mcand_q  <= mcand_d;
      mulh_q   <= mulh_d;
      cnt_q    <= cnt_d;
    end
  end

endmodule

// File: tb/tb_alu_seq.sv
// Testbench for alu_seq: directed and random ops checked against an integer-arithmetic reference model.
module tb_alu_seq;

  localparam int unsigned W = 8;

  logic         clock = 1'b0;
  logic         reset = 1'b1;
  logic         start = 1'b0;
  logic [3:0]   op = '0;
  logic [W-1:0] a = '0;
  logic [W-1:0] b = '0;
  logic [W-1:0] result;
  logic [3:0]   flags;
  logic         busy;
  logic         done;

  int vectors = 0;
  int miscompares = 0;

  logic [W-1:0] m_result = '0;
  logic [3:0]   m_flags = '0;

  alu_seq #(.DATA_BUS_WIDTH(W)) dut (
    .clock(clock), .reset(reset), .start(start), .op(op), .a(a), .b(b),
    .result(result), .flags(flags), .busy(busy), .done(done)
  );

  always #5 clock = ~clock;

  // Reference: plain integer arithmetic on the architectural rules
  function automatic void model(input logic [3:0] o, input logic [7:0] x, input logic [7:0] y);
    int ua, ub, sa, sb, c, r, sr, nc, v, p;
    bit upd;
    logic [7:0] r8;
    ua = int'(x); ub = int'(y);
    sa = (ua >= 128) ? ua - 256 : ua;
    sb = (ub >= 128) ? ub - 256 : ub;
    c  = int'(m_flags[1]);
    p  = ua * ub;
    nc = c; v = 0; upd = 1'b1; r = 0; sr = 0;
    case (o)
      4'h0: begin r = ua + ub;     nc = (r > 255) ? 1 : 0;      sr = sa + sb;     v = (sr > 127 || sr < -128) ? 1 : 0; end
      4'h1: begin r = ua + ub + c; nc = (r > 255) ? 1 : 0;      sr = sa + sb + c; v = (sr > 127 || sr < -128) ? 1 : 0; end
      4'h2: begin r = ua - ub;     nc = (ua < ub) ? 1 : 0;      sr = sa - sb;     v = (sr > 127 || sr < -128) ? 1 : 0; end
      4'h3: begin r = ua - ub - c; nc = (ua < ub + c) ? 1 : 0;  sr = sa - sb - c; v = (sr > 127 || sr < -128) ? 1 : 0; end
      4'h4: r = int'(x & y);
      4'h5: r = int'(x | y);
      4'h6: r = int'(x ^ y);
      4'h7: r = 255 - ua;
      4'h8: begin r = ua * 2;     nc = (ua >= 128) ? 1 : 0; end
      4'h9: begin r = ua / 2;     nc = ua % 2; end
      4'hA: begin r = ua * 2 + c; nc = (ua >= 128) ? 1 : 0; end
      4'hB: begin r = ua + 1;     v = (ua == 127) ? 1 : 0; end
      4'hC: begin r = ua - 1;     v = (ua == 128) ? 1 : 0; end
      4'hD: begin r = p % 256;    nc = (p / 256 != 0) ? 1 : 0; end
      4'hE: begin r = p / 256;    nc = (p % 256 != 0) ? 1 : 0; end
      default: begin r = ua - ub; nc = (ua < ub) ? 1 : 0; sr = sa - sb; v = (sr > 127 || sr < -128) ? 1 : 0; upd = 1'b0; end
    endcase
    r8 = 8'(r);
    if (upd) m_result = r8;
    m_flags = {r8[7], (v != 0), (nc != 0), (r8 == 8'h00)};
  endfunction

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  // Present one accepted start, then scramble operands to prove they were latched
  task automatic issue(input logic [3:0] o, input logic [7:0] x, input logic [7:0] y);
    start = 1'b1; op = o; a = x; b = y;
    tick();
    start = 1'b0; a = 8'($urandom); b = 8'($urandom);
  endtask

  task automatic test_reset();
    reset = 1'b1; start = 1'b0;
    tick(); tick();
    reset = 1'b0;
    m_result = '0; m_flags = '0;
    for (int i = 0; i < 4; i++) begin
      vectors++;
      if ({busy, done, flags, result} !== 14'h0) begin
        miscompares++;
        $display("FAIL reset_idle[%0d] got busy=%b done=%b flags=%b result=%h exp all zero", i, busy, done, flags, result);
      end
      if (i < 3) tick();
    end
  endtask

  task automatic test_arith();
    logic [19:0] vec [7] = '{20'h0_7F_01, 20'h1_FF_01, 20'h0_FF_01, 20'h1_00_00,
                             20'h0_80_80, 20'h2_10_20, 20'h3_00_00};
    foreach (vec[i]) begin
      issue(vec[i][19:16], vec[i][15:8], vec[i][7:0]);
      model(vec[i][19:16], vec[i][15:8], vec[i][7:0]);
      vectors++;
      if ({done, busy, flags, result} !== {1'b1, 1'b0, m_flags, m_result}) begin
        miscompares++;
        $display("FAIL arith[%0d] op=%h got done=%b busy=%b flags=%b result=%h exp flags=%b result=%h",
                 i, vec[i][19:16], done, busy, flags, result, m_flags, m_result);
      end
    end
    // Plan constant: 0x7F+0x01 overflow gives 0x80 with N and V set
    issue(4'h0, 8'h7F, 8'h01);
    model(4'h0, 8'h7F, 8'h01);
    vectors++;
    if ({flags, result} !== 12'hC80) begin
      miscompares++;
      $display("FAIL add_overflow got flags=%b result=%h exp flags=1100 result=80", flags, result);
    end
  endtask

  task automatic test_sub_cmp();
    logic [19:0] vec [6] = '{20'h2_10_20, 20'hF_05_05, 20'hF_03_09, 20'h3_50_B0,
                             20'h2_80_01, 20'hF_7F_80};
    foreach (vec[i]) begin
      issue(vec[i][19:16], vec[i][15:8], vec[i][7:0]);
      model(vec[i][19:16], vec[i][15:8], vec[i][7:0]);
      vectors++;
      if ({done, flags, result} !== {1'b1, m_flags, m_result}) begin
        miscompares++;
        $display("FAIL sub_cmp[%0d] op=%h got done=%b flags=%b result=%h exp flags=%b result=%h",
                 i, vec[i][19:16], done, flags, result, m_flags, m_result);
      end
    end
  endtask

  task automatic test_logic_shift();
    logic [19:0] vec [13] = '{20'h8_80_00, 20'h4_F0_3C, 20'hA_01_00, 20'h5_0F_30, 20'h6_FF_0F,
                              20'h7_5A_00, 20'h9_03_00, 20'hA_80_00, 20'hA_40_00, 20'hB_7F_00,
                              20'hB_FF_00, 20'hC_80_00, 20'hC_00_00};
    foreach (vec[i]) begin
      issue(vec[i][19:16], vec[i][15:8], vec[i][7:0]);
      model(vec[i][19:16], vec[i][15:8], vec[i][7:0]);
      vectors++;
      if ({done, flags, result} !== {1'b1, m_flags, m_result}) begin
        miscompares++;
        $display("FAIL logic_shift[%0d] op=%h got done=%b flags=%b result=%h exp flags=%b result=%h",
                 i, vec[i][19:16], done, flags, result, m_flags, m_result);
      end
    end
  endtask

  task automatic test_done_drop();
    issue(4'h5, 8'h11, 8'h22);
    model(4'h5, 8'h11, 8'h22);
    tick();
    vectors++;
    if ({done, busy, flags, result} !== {1'b0, 1'b0, m_flags, m_result}) begin
      miscompares++;
      $display("FAIL done_drop got done=%b busy=%b flags=%b result=%h exp done=0 flags=%b result=%h",
               done, busy, flags, result, m_flags, m_result);
    end
  endtask

  task automatic test_back_to_back();
    logic [3:0] o;
    logic [7:0] x, y;
    start = 1'b1;
    for (int i = 0; i < 8; i++) begin
      o = 4'($urandom_range(0, 12));
      if (i % 3 == 2) o = 4'hF;
      x = 8'($urandom); y = 8'($urandom);
      op = o; a = x; b = y;
      tick();
      model(o, x, y);
      vectors++;
      if ({done, busy, flags, result} !== {1'b1, 1'b0, m_flags, m_result}) begin
        miscompares++;
        $display("FAIL back_to_back[%0d] op=%h got done=%b busy=%b flags=%b result=%h exp flags=%b result=%h",
                 i, o, done, busy, flags, result, m_flags, m_result);
      end
    end
    start = 1'b0;
    tick();
    vectors++;
    if (done !== 1'b0) begin
      miscompares++;
      $display("FAIL back_to_back_end got done=%b exp 0", done);
    end
  endtask

  // MUL then MULH on 0x12*0x34 with a stray start mid-multiply
  task automatic test_mul();
    logic [3:0]  ops [2] = '{4'hD, 4'hE};
    logic [11:0] old;
    foreach (ops[k]) begin
      old = {m_flags, m_result};
      issue(ops[k], 8'h12, 8'h34);
      model(ops[k], 8'h12, 8'h34);
      for (int i = 0; i <= int'(W); i++) begin
        if (i == 3) begin start = 1'b1; op = 4'h0; a = 8'h01; b = 8'h01; end
        if (i > 0) tick();
        start = 1'b0;
        vectors++;
        if (i < int'(W)) begin
          if ({busy, done, flags, result} !== {1'b1, 1'b0, old}) begin
            miscompares++;
            $display("FAIL mul_busy op=%h cyc=%0d got busy=%b done=%b flags=%b result=%h exp busy=1 done=0 hold %h",
                     ops[k], i, busy, done, flags, result, old);
          end
        end else if ({busy, done, flags, result} !== {1'b0, 1'b1, m_flags, m_result}) begin
          miscompares++;
          $display("FAIL mul_done op=%h got busy=%b done=%b flags=%b result=%h exp flags=%b result=%h",
                   ops[k], busy, done, flags, result, m_flags, m_result);
        end
      end
      tick();
      vectors++;
      if ({busy, done} !== 2'b00) begin
        miscompares++;
        $display("FAIL mul_after op=%h got busy=%b done=%b exp 0 0", ops[k], busy, done);
      end
    end
    vectors++;
    if (result !== 8'h03) begin
      miscompares++;
      $display("FAIL mulh_const got result=%h exp 03", result);
    end
  endtask

  // A start presented on the completing edge must be dropped
  task automatic test_mul_edge_start();
    issue(4'hD, 8'hF3, 8'h2B);
    model(4'hD, 8'hF3, 8'h2B);
    repeat (int'(W) - 1) tick();
    start = 1'b1; op = 4'h0; a = 8'h05; b = 8'h06;
    tick();
    start = 1'b0;
    vectors++;
    if ({busy, done, flags, result} !== {1'b0, 1'b1, m_flags, m_result}) begin
      miscompares++;
      $display("FAIL mul_edge_done got busy=%b done=%b flags=%b result=%h exp flags=%b result=%h",
               busy, done, flags, result, m_flags, m_result);
    end
    tick();
    vectors++;
    if ({busy, done, flags, result} !== {1'b0, 1'b0, m_flags, m_result}) begin
      miscompares++;
      $display("FAIL mul_edge_ignored got busy=%b done=%b flags=%b result=%h exp done=0 flags=%b result=%h",
               busy, done, flags, result, m_flags, m_result);
    end
  endtask

  task automatic test_reset_mid_mul();
    reset = 1'b1; tick(); reset = 1'b0;
    m_result = '0; m_flags = '0;
    issue(4'hD, 8'hFF, 8'hFF);
    tick(); tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    for (int i = 0; i < 12; i++) begin
      vectors++;
      if ({busy, done, flags, result} !== 14'h0) begin
        miscompares++;
        $display("FAIL reset_mid_mul[%0d] got busy=%b done=%b flags=%b result=%h exp all zero",
                 i, busy, done, flags, result);
      end
      tick();
    end
    issue(4'h0, 8'h01, 8'h02);
    model(4'h0, 8'h01, 8'h02);
    vectors++;
    if ({done, flags, result} !== {1'b1, 4'b0000, 8'h03}) begin
      miscompares++;
      $display("FAIL reset_then_add got done=%b flags=%b result=%h exp done=1 flags=0000 result=03", done, flags, result);
    end
  endtask

  task automatic test_random();
    logic [3:0]  o;
    logic [7:0]  x, y;
    logic [11:0] old;
    for (int n = 0; n < 250; n++) begin
      o = 4'($urandom_range(0, 15));
      x = 8'($urandom); y = 8'($urandom);
      old = {m_flags, m_result};
      issue(o, x, y);
      model(o, x, y);
      if (o == 4'hD || o == 4'hE) begin
        for (int i = 1; i <= int'(W); i++) begin
          vectors++;
          if ({busy, done, flags, result} !== {1'b1, 1'b0, old}) begin
            miscompares++;
            $display("FAIL rand_busy n=%0d op=%h cyc=%0d got busy=%b done=%b flags=%b result=%h exp hold %h",
                     n, o, i, busy, done, flags, result, old);
          end
          start = 1'($urandom_range(0, 1)); op = 4'($urandom); a = 8'($urandom); b = 8'($urandom);
          tick();
          start = 1'b0;
        end
      end
      vectors++;
      if ({busy, done, flags, result} !== {1'b0, 1'b1, m_flags, m_result}) begin
        miscompares++;
        $display("FAIL rand n=%0d op=%h a=%h b=%h got busy=%b done=%b flags=%b result=%h exp flags=%b result=%h",
                 n, o, x, y, busy, done, flags, result, m_flags, m_result);
      end
      if ($urandom_range(0, 3) == 0) begin
        tick();
        vectors++;
        if ({busy, done, flags, result} !== {1'b0, 1'b0, m_flags, m_result}) begin
          miscompares++;
          $display("FAIL rand_idle n=%0d got busy=%b done=%b flags=%b result=%h exp done=0 flags=%b result=%h",
                   n, busy, done, flags, result, m_flags, m_result);
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_arith();
    test_sub_cmp();
    test_logic_shift();
    test_done_drop();
    test_back_to_back();
    test_mul();
    test_mul_edge_start();
    test_reset_mid_mul();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
